jk_mod_counter: RTL and testbench
=================================

# jk_mod_counter

Parametrised synchronous modulo-N counter built from JK flip-flop cells with per-bit J/K toggle-enable logic. It is the general successor of the fixed 4-bit JK up-counter: configurable width and modulus, count enable, up/down direction, synchronous parallel load, and a terminal-count output for cascading stages into multi-digit counters, for example BCD decades.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits, legal range 2..16.
- `MODULUS`, default 16: count sequence length, legal range 2..2^WIDTH. Count values run 0..MODULUS-1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable; holds the count when low.
- `up_dn`  in  1  direction: 1 = up, 0 = down.
- `load`  in  1  synchronous parallel load strobe.
- `din`  in  WIDTH  load value.
- `count`  out  WIDTH  current count, taken directly from the JK cell Q outputs (no extra register stage).
- `tc`  out  1  combinational terminal count: `en` & (up ? count==MODULUS-1 : count==0); drives `en` of the next stage.
- `wrap`  out  1  registered one-cycle pulse in the cycle after a wrap-around occurred.

## Operation
- Each bit is a JK cell with J=K=toggle, or forced set/clear (J/K = 1/0 or 0/1) during load and wrap. No behavioural `+`/`-` on the count register.
- Up toggle for bit i: `en` & AND(count[i-1:0]). Down toggle for bit i: `en` & AND(~count[i-1:0]).
- Priority per edge: `reset_n` low > `load` > wrap > normal toggle > hold.
- Load: `count` <= `din` when `din` < MODULUS; otherwise `count` <= 0. Load ignores `en`. Load never asserts `wrap`.
- Up wrap: `en` & up & count==MODULUS-1 -> count <= 0.
- Down wrap: `en` & ~up & count==0 -> count <= MODULUS-1.
- `wrap` <= 1 on the edge where a wrap is taken, and <= 0 otherwise.
- `up_dn` may change on any cycle. The value sampled at the edge determines the next count. No glitch or lost count is permitted on a direction reversal.
- When MODULUS == 2^WIDTH, the wrap logic degenerates to natural binary rollover with identical outputs.

## Timing
- Reset (asynchronous assert, synchronous-safe release): `count`=0, `wrap`=0. `tc`=0 while reset is held if `en`=0; otherwise `tc` follows its equation with count=0.
- Count, load and wrap latency: 1 clock edge. `count` is valid immediately after the edge.
- `tc` has zero latency relative to `count`/`en`/`up_dn`. Cascade by connecting stage k `tc` to stage k+1 `en`. The whole chain advances on the same edge.
- Reset asserted mid-count: outputs clear immediately without waiting for `clk`. The first edge after release with `en`=1 produces count=1 (up) or MODULUS-1 (down).
- Simultaneous `load` and terminal condition: load wins, and `wrap` stays 0.

## Configuration
- `JK_MOD_COUNTER_UPDOWN_EN`: when defined, the `up_dn` input and the down toggle/wrap logic are compiled in as described above.
- When not defined: `up_dn` is ignored (port retained, unconnected internally). The counter counts up only, `tc` = `en` & count==MODULUS-1, and the down-wrap path is removed.

## Test plan
Each scenario uses WIDTH=4, MODULUS=10 unless stated otherwise.
- Reset then 12 edges with en=1, up=1 -> count 1,2,…,9,0,1,2. `wrap`=1 only in the cycle after 9->0. `tc`=1 only while count=9.
- Down count from reset with macro defined, 3 edges -> 9,8,7. `wrap` pulses after 0->9. `tc`=1 while count=0.
- load=1, din=7 with en=0 -> count=7. Then load din=12 -> count=0. Load on the count=9 cycle with en=1, din=3 -> count=3, `wrap`=0.
- reset_n pulsed low mid-edge-interval at count=6 -> count=0 and wrap=0 before the next clk edge. First edge after release -> 1.
- Two cascaded instances (stage0.tc -> stage1.en), 25 edges -> {stage1,stage0} = {2,5}. The stage1 increment coincides with stage0 9->0.
- WIDTH=4, MODULUS=16, macro undefined, up_dn toggled randomly -> count increments every edge, 15->0 rollover with `wrap`=1.

Source files
------------

// File: rtl/jk_mod_counter.sv
// Modulo-N counter of JK cells (J=K=toggle, forced J/K on load/wrap); 1-cycle count/load latency, tc combinational.
// No backpressure: en gates counting, load overrides en. JK_MOD_COUNTER_UPDOWN_EN adds the down direction.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] j_c, k_c, load_val;
  logic             dir_up, at_max, at_min, up_wrap, dn_wrap, tc_c;
  logic             up_run, dn_run, tog;

`ifndef JK_MOD_COUNTER_UPDOWN_EN
  logic unused_up_dn;
  assign unused_up_dn = up_dn;
`endif

  always_comb begin
    load_val = ({1'b0, din} < MOD_W) ? din : '0;
    at_max   = (count_q == MAX_VAL);
`ifdef JK_MOD_COUNTER_UPDOWN_EN
    dir_up   = up_dn;
    at_min   = (count_q == '0);
    tc_c     = en & (dir_up ? at_max : at_min);
`else
    dir_up   = 1'b1;
    at_min   = 1'b0;
    tc_c     = en & at_max;
`endif
    up_wrap  = en & dir_up & at_max;
    dn_wrap  = en & ~dir_up & at_min;
    j_c      = '0;
    k_c      = '0;
    up_run   = 1'b1;
    dn_run   = 1'b1;
    tog      = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      // up_run/dn_run hold AND of lower bits (or their complements) before bit i
      if (load) begin
        j_c[i] = load_val[i];
        k_c[i] = ~load_val[i];
      end else if (up_wrap) begin
        j_c[i] = 1'b0;
        k_c[i] = 1'b1;
      end else if (dn_wrap) begin
        j_c[i] = MAX_VAL[i];
        k_c[i] = ~MAX_VAL[i];
      end else begin
        tog    = en & (dir_up ? up_run : dn_run);
        j_c[i] = tog;
        k_c[i] = tog;
      end
      up_run = up_run & count_q[i];
      dn_run = dn_run & ~count_q[i];
    end
    count_d = (j_c & ~count_q) | (~k_c & count_q);
    wrap_d  = ~load & (up_wrap | dn_wrap);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_c;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter: mod-10 single stage, two-stage cascade, mod-16 rollover.
module tb_jk_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // single mod-10 stage
  logic       a_rst_n, a_en, a_up, a_load, a_tc, a_wrap;
  logic [3:0] a_din, a_count;
  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .reset_n(a_rst_n), .en(a_en), .up_dn(a_up), .load(a_load),
    .din(a_din), .count(a_count), .tc(a_tc), .wrap(a_wrap)
  );

  // cascaded mod-10 stages
  logic       c_rst_n, c_en, c0_tc, c0_wrap, c1_tc, c1_wrap;
  logic [3:0] c0_count, c1_count;
  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) stage0 (
    .clk(clk), .reset_n(c_rst_n), .en(c_en), .up_dn(1'b1), .load(1'b0),
    .din(4'd0), .count(c0_count), .tc(c0_tc), .wrap(c0_wrap)
  );
  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) stage1 (
    .clk(clk), .reset_n(c_rst_n), .en(c0_tc), .up_dn(1'b1), .load(1'b0),
    .din(4'd0), .count(c1_count), .tc(c1_tc), .wrap(c1_wrap)
  );

  // full-range mod-16 stage
  logic       f_rst_n, f_up, f_tc, f_wrap;
  logic [3:0] f_count;
  jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .reset_n(f_rst_n), .en(1'b1), .up_dn(f_up), .load(1'b0),
    .din(4'd0), .count(f_count), .tc(f_tc), .wrap(f_wrap)
  );

  initial begin
    a_rst_n = 1'b0; a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_din = 4'd0;
    c_rst_n = 1'b0; c_en = 1'b0;
    f_rst_n = 1'b0; f_up = 1'b1;
    #12;
    chk("rst_count", {12'd0, a_count}, 16'd0);
    chk("rst_wrap", {15'd0, a_wrap}, 16'd0);
    chk("rst_tc", {15'd0, a_tc}, 16'd0);

    a_rst_n = 1'b1;
    a_en    = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      chk("up_count", {12'd0, a_count}, 16'(n % 10));
      chk("up_wrap", {15'd0, a_wrap}, (n == 10) ? 16'd1 : 16'd0);
      chk("up_tc", {15'd0, a_tc}, ((n % 10) == 9) ? 16'd1 : 16'd0);
    end

    // loads: ignore en, clamp out-of-range values to 0
    a_en = 1'b0; a_load = 1'b1; a_din = 4'd7;
    step();
    chk("load7", {12'd0, a_count}, 16'd7);
    chk("load7_tc", {15'd0, a_tc}, 16'd0);
    a_din = 4'd12;
    step();
    chk("load12", {12'd0, a_count}, 16'd0);
    a_din = 4'd9;
    step();
    chk("load9", {12'd0, a_count}, 16'd9);
    a_din = 4'd10;
    step();
    chk("load10", {12'd0, a_count}, 16'd0);
    a_load = 1'b0; a_en = 1'b1;
    for (int n = 0; n < 9; n++) step();
    chk("pre_load_cnt", {12'd0, a_count}, 16'd9);
    chk("pre_load_tc", {15'd0, a_tc}, 16'd1);
    a_load = 1'b1; a_din = 4'd3;
    step();
    chk("load_tc_cnt", {12'd0, a_count}, 16'd3);
    chk("load_tc_wrap", {15'd0, a_wrap}, 16'd0);
    a_load = 1'b0;

    // asynchronous reset in the middle of a clock interval
    for (int n = 0; n < 3; n++) step();
    chk("mid_cnt", {12'd0, a_count}, 16'd6);
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("async_cnt", {12'd0, a_count}, 16'd0);
    chk("async_wrap", {15'd0, a_wrap}, 16'd0);
    a_rst_n = 1'b1;
    step();
    chk("post_rst", {12'd0, a_count}, 16'd1);

`ifdef JK_MOD_COUNTER_UPDOWN_EN
    a_rst_n = 1'b0;
    a_up    = 1'b0;
    #1;
    a_rst_n = 1'b1;
    #1;
    chk("dn_tc0", {15'd0, a_tc}, 16'd1);
    step();
    chk("dn_9", {12'd0, a_count}, 16'd9);
    chk("dn_wrap", {15'd0, a_wrap}, 16'd1);
    chk("dn_tc9", {15'd0, a_tc}, 16'd0);
    step();
    chk("dn_8", {12'd0, a_count}, 16'd8);
    chk("dn_wrap8", {15'd0, a_wrap}, 16'd0);
    step();
    chk("dn_7", {12'd0, a_count}, 16'd7);
    a_up = 1'b1;
    step();
    chk("rev_up", {12'd0, a_count}, 16'd8);
    a_up = 1'b0;
    step();
    chk("rev_dn", {12'd0, a_count}, 16'd7);
`endif

    // two-digit decade cascade
    c_rst_n = 1'b1;
    c_en    = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      step();
      chk("casc", {8'd0, c1_count, c0_count}, {8'd0, 4'(n / 10), 4'(n % 10)});
      chk("casc_wrap", {14'd0, c1_wrap, c0_wrap}, ((n % 10) == 0) ? 16'd1 : 16'd0);
    end
    chk("casc_tc1", {15'd0, c1_tc}, 16'd0);

`ifndef JK_MOD_COUNTER_UPDOWN_EN
    f_rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      f_up = 1'($urandom_range(0, 1));
      step();
      chk("m16_count", {12'd0, f_count}, 16'(n % 16));
      chk("m16_wrap", {15'd0, f_wrap}, (n == 16) ? 16'd1 : 16'd0);
      chk("m16_tc", {15'd0, f_tc}, ((n % 16) == 15) ? 16'd1 : 16'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
